// File: rtl/i2c_arbiter_if.sv
// i2c_arbiter_if: bundles the two requester ports (m0_*, m1_*) and the
// i2c_dri command/response signals used by i2c_arbiter.
//   slave  modport : arbiter side (requester commands and i2c_dri responses in,
//                    requester responses and i2c_dri commands out)
//   master modport : environment side (requesters plus i2c_dri), the mirror image
// WIDTH sets the width of every reg_num field.
interface i2c_arbiter_if #(parameter int WIDTH = 8);
  // requester 0
  logic             m0_exec, m0_rh_wl, m0_bit_ctrl;
  logic [6:0]       m0_slave_addr;
  logic [15:0]      m0_addr;
  logic [7:0]       m0_data_w;
  logic [WIDTH-1:0] m0_reg_num;
  logic [7:0]       m0_data_r;
  logic             m0_byte_done, m0_ack, m0_done, m0_err, m0_busy;
  // requester 1
  logic             m1_exec, m1_rh_wl, m1_bit_ctrl;
  logic [6:0]       m1_slave_addr;
  logic [15:0]      m1_addr;
  logic [7:0]       m1_data_w;
  logic [WIDTH-1:0] m1_reg_num;
  logic [7:0]       m1_data_r;
  logic             m1_byte_done, m1_ack, m1_done, m1_err, m1_busy;
  // i2c_dri side
  logic             i2c_exec, i2c_rh_wl, bit_ctrl;
  logic [6:0]       slave_addr;
  logic [15:0]      i2c_addr;
  logic [7:0]       i2c_data_w;
  logic [WIDTH-1:0] reg_num;
  logic [7:0]       i2c_data_r;
  logic             i2c_done, once_byte_done, i2c_ack;

  modport slave (
    input  m0_exec, m0_rh_wl, m0_slave_addr, m0_addr, m0_data_w, m0_bit_ctrl, m0_reg_num,
    input  m1_exec, m1_rh_wl, m1_slave_addr, m1_addr, m1_data_w, m1_bit_ctrl, m1_reg_num,
    input  i2c_data_r, i2c_done, once_byte_done, i2c_ack,
    output m0_data_r, m0_byte_done, m0_ack, m0_done, m0_err, m0_busy,
    output m1_data_r, m1_byte_done, m1_ack, m1_done, m1_err, m1_busy,
    output i2c_exec, i2c_rh_wl, slave_addr, i2c_addr, i2c_data_w, bit_ctrl, reg_num
  );

  modport master (
    output m0_exec, m0_rh_wl, m0_slave_addr, m0_addr, m0_data_w, m0_bit_ctrl, m0_reg_num,
    output m1_exec, m1_rh_wl, m1_slave_addr, m1_addr, m1_data_w, m1_bit_ctrl, m1_reg_num,
    output i2c_data_r, i2c_done, once_byte_done, i2c_ack,
    input  m0_data_r, m0_byte_done, m0_ack, m0_done, m0_err, m0_busy,
    input  m1_data_r, m1_byte_done, m1_ack, m1_done, m1_err, m1_busy,
    input  i2c_exec, i2c_rh_wl, slave_addr, i2c_addr, i2c_data_w, bit_ctrl, reg_num
  );
endinterface

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c_dri between two requesters (m0, m1).
// Each requester posts a command with a one-cycle mX_exec pulse; the command
// is latched and held pending (mX_busy) until its transfer completes.  Pending
// requests are granted round-robin, issued to i2c_dri with a one-cycle
// i2c_exec, and byte-level responses are routed back to the granted requester.
// A WAIT watchdog aborts a transfer after TIMEOUT cycles with mX_err = 1.
// Ports:
//   clk   - i2c driver clock (dri_clk)
//   rst_n - asynchronous active-low reset
//   bus   - i2c_arbiter_if.slave (requester and i2c_dri signals)
module i2c_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 65535
) (
  input logic           clk,
  input logic           rst_n,
  i2c_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  state_t           state;
  logic             grant, last_grant, pick;
  logic [1:0]       pend, done_q, err_q, sel;
  logic [15:0]      tcnt;

  // requester inputs gathered into indexable form
  logic [1:0]       exec_in, rw_in, bc_in;
  logic [6:0]       sa_in   [2];
  logic [15:0]      addr_in [2];
  logic [7:0]       dw_in   [2];
  logic [WIDTH-1:0] rn_in   [2];

  // per-requester command registers
  logic [1:0]       c_rw, c_bc;
  logic [6:0]       c_sa   [2];
  logic [15:0]      c_addr [2];
  logic [WIDTH-1:0] c_rn   [2];
  logic [7:0]       data_r_q [2];

  // registered i2c_dri command outputs
  logic             exec_q, rw_q, bc_q;
  logic [6:0]       sa_q;
  logic [15:0]      addr_q;
  logic [WIDTH-1:0] rn_q;

  assign exec_in    = {bus.m1_exec, bus.m0_exec};
  assign rw_in      = {bus.m1_rh_wl, bus.m0_rh_wl};
  assign bc_in      = {bus.m1_bit_ctrl, bus.m0_bit_ctrl};
  assign sa_in[0]   = bus.m0_slave_addr;
  assign sa_in[1]   = bus.m1_slave_addr;
  assign addr_in[0] = bus.m0_addr;
  assign addr_in[1] = bus.m1_addr;
  assign dw_in[0]   = bus.m0_data_w;
  assign dw_in[1]   = bus.m1_data_w;
  assign rn_in[0]   = bus.m0_reg_num;
  assign rn_in[1]   = bus.m1_reg_num;

  // On a tie the requester that was not served last wins.
  assign pick = (&pend) ? ~last_grant : pend[1];
  // One-hot of the requester currently connected to i2c_dri responses.
  assign sel  = (state == WAIT) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // Request capture.  A new exec during the requester's own done cycle is
  // accepted: the set takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      c_rw <= '0;
      c_bc <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        c_sa[i]     <= '0;
        c_addr[i]   <= '0;
        c_rn[i]     <= '0;
        data_r_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (exec_in[i] && (!pend[i] || done_q[i])) begin
          pend[i]   <= 1'b1;
          c_rw[i]   <= rw_in[i];
          c_bc[i]   <= bc_in[i];
          c_sa[i]   <= sa_in[i];
          c_addr[i] <= addr_in[i];
          c_rn[i]   <= rn_in[i];
        end else if (done_q[i]) begin
          pend[i] <= 1'b0;
        end
        if (sel[i]) data_r_q[i] <= bus.i2c_data_r;
      end
    end
  end

  // Arbitration / transfer FSM.  exec_q and done_q/err_q are set on the
  // transition into ISSUE/DONE so they are high exactly during that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      tcnt       <= '0;
      exec_q     <= 1'b0;
      rw_q       <= 1'b0;
      bc_q       <= 1'b0;
      sa_q       <= '0;
      addr_q     <= '0;
      rn_q       <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      exec_q <= 1'b0;
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: if (|pend) begin
          grant  <= pick;
          exec_q <= 1'b1;
          rw_q   <= c_rw[pick];
          bc_q   <= c_bc[pick];
          sa_q   <= c_sa[pick];
          addr_q <= c_addr[pick];
          rn_q   <= c_rn[pick];
          tcnt   <= '0;
          state  <= ISSUE;
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.i2c_done) begin
            done_q[grant] <= 1'b1;
            state         <= DONE;
          end else if (tcnt == TLIM) begin
            // this WAIT cycle is the TIMEOUT-th one
            done_q[grant] <= 1'b1;
            err_q[grant]  <= 1'b1;
            state         <= DONE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.i2c_exec   = exec_q;
  assign bus.i2c_rh_wl  = rw_q;
  assign bus.bit_ctrl   = bc_q;
  assign bus.slave_addr = sa_q;
  assign bus.i2c_addr   = addr_q;
  assign bus.reg_num    = rn_q;
  // Write data is live so a requester can refresh it after each byte_done;
  // forced to zero when idle so it is quiet in and after reset.
  assign bus.i2c_data_w = (state == IDLE) ? '0 : dw_in[grant];

  assign bus.m0_byte_done = sel[0] & bus.once_byte_done;
  assign bus.m1_byte_done = sel[1] & bus.once_byte_done;
  assign bus.m0_ack       = sel[0] & bus.i2c_ack;
  assign bus.m1_ack       = sel[1] & bus.i2c_ack;
  assign bus.m0_data_r    = sel[0] ? bus.i2c_data_r : data_r_q[0];
  assign bus.m1_data_r    = sel[1] ? bus.i2c_data_r : data_r_q[1];
  assign bus.m0_done      = done_q[0];
  assign bus.m1_done      = done_q[1];
  assign bus.m0_err       = err_q[0];
  assign bus.m1_err       = err_q[1];
  assign bus.m0_busy      = pend[0];
  assign bus.m1_busy      = pend[1];

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed testbench for i2c_arbiter (TIMEOUT overridden to 20).
module tb_i2c_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   vec  = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  i2c_arbiter_if #(.WIDTH(8)) bus ();
  i2c_arbiter #(.WIDTH(8), .TIMEOUT(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  function automatic logic [67:0] outs();
    return {bus.i2c_exec, bus.i2c_rh_wl, bus.slave_addr, bus.i2c_addr, bus.i2c_data_w,
            bus.bit_ctrl, bus.reg_num,
            bus.m0_data_r, bus.m0_byte_done, bus.m0_ack, bus.m0_done, bus.m0_err, bus.m0_busy,
            bus.m1_data_r, bus.m1_byte_done, bus.m1_ack, bus.m1_done, bus.m1_err, bus.m1_busy};
  endfunction

  task automatic clr_inputs();
    bus.m0_exec = 0; bus.m0_rh_wl = 0; bus.m0_slave_addr = '0; bus.m0_addr = '0;
    bus.m0_data_w = '0; bus.m0_bit_ctrl = 0; bus.m0_reg_num = '0;
    bus.m1_exec = 0; bus.m1_rh_wl = 0; bus.m1_slave_addr = '0; bus.m1_addr = '0;
    bus.m1_data_w = '0; bus.m1_bit_ctrl = 0; bus.m1_reg_num = '0;
    bus.i2c_data_r = '0; bus.i2c_done = 0; bus.once_byte_done = 0; bus.i2c_ack = 0;
  endtask

  task automatic set_req(input bit m, input logic rw, input logic [6:0] sa,
                         input logic [15:0] a, input logic [7:0] dw,
                         input logic bc, input logic [7:0] rn);
    if (!m) begin
      bus.m0_rh_wl = rw; bus.m0_slave_addr = sa; bus.m0_addr = a;
      bus.m0_data_w = dw; bus.m0_bit_ctrl = bc; bus.m0_reg_num = rn;
    end else begin
      bus.m1_rh_wl = rw; bus.m1_slave_addr = sa; bus.m1_addr = a;
      bus.m1_data_w = dw; bus.m1_bit_ctrl = bc; bus.m1_reg_num = rn;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    vec++;
    if (outs() !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", outs()); end
    rst_n = 1'b1;
    @(negedge clk);
    vec++;
    if (outs() !== '0) begin errs++; $display("FAIL reset_release_quiet: got %h want 0", outs()); end
  endtask

  task automatic test_single_write();
    set_req(0, 1'b0, 7'h14, 16'h8140, 8'h5A, 1'b1, 8'd1);
    @(negedge clk); bus.m0_exec = 1;
    @(negedge clk); bus.m0_exec = 0;
    vec++;
    if ({bus.m0_busy, bus.i2c_exec} !== 2'b10) begin
      errs++; $display("FAIL single_lat1 busy/exec: got %b want 10", {bus.m0_busy, bus.i2c_exec});
    end
    @(negedge clk);
    vec++;
    if (bus.i2c_exec !== 1'b1) begin errs++; $display("FAIL single_exec_lat2: got %b want 1", bus.i2c_exec); end
    vec++;
    if ({bus.i2c_rh_wl, bus.slave_addr, bus.i2c_addr, bus.bit_ctrl, bus.reg_num, bus.i2c_data_w}
        !== {1'b0, 7'h14, 16'h8140, 1'b1, 8'd1, 8'h5A}) begin
      errs++; $display("FAIL single_cmd: got sa=%h addr=%h dw=%h want sa=14 addr=8140 dw=5a",
                       bus.slave_addr, bus.i2c_addr, bus.i2c_data_w);
    end
    @(negedge clk);
    vec++;
    if (bus.i2c_exec !== 1'b0) begin errs++; $display("FAIL single_exec_one_cycle: got %b want 0", bus.i2c_exec); end
    bus.once_byte_done = 1; bus.i2c_ack = 1;
    #1;
    vec++;
    if ({bus.m0_byte_done, bus.m0_ack, bus.m1_byte_done, bus.m1_ack} !== 4'b1100) begin
      errs++; $display("FAIL single_route: got %b want 1100",
                       {bus.m0_byte_done, bus.m0_ack, bus.m1_byte_done, bus.m1_ack});
    end
    @(negedge clk); bus.once_byte_done = 0; bus.i2c_ack = 0; bus.i2c_done = 1;
    @(negedge clk); bus.i2c_done = 0;
    vec++;
    if ({bus.m0_done, bus.m0_err, bus.m1_done} !== 3'b100) begin
      errs++; $display("FAIL single_done: got %b want 100", {bus.m0_done, bus.m0_err, bus.m1_done});
    end
    @(negedge clk);
    vec++;
    if ({bus.m0_done, bus.m0_busy} !== 2'b00) begin
      errs++; $display("FAIL single_after_done: got %b want 00", {bus.m0_done, bus.m0_busy});
    end
  endtask

  task automatic test_tie();
    do_reset();
    set_req(0, 1'b0, 7'h10, 16'h0010, 8'h00, 1'b0, 8'd1);
    set_req(1, 1'b0, 7'h21, 16'h2100, 8'h00, 1'b0, 8'd1);
    @(negedge clk); bus.m0_exec = 1; bus.m1_exec = 1;
    @(negedge clk); bus.m0_exec = 0; bus.m1_exec = 0;
    vec++;
    if ({bus.m0_busy, bus.m1_busy} !== 2'b11) begin
      errs++; $display("FAIL tie_busy: got %b want 11", {bus.m0_busy, bus.m1_busy});
    end
    @(negedge clk);
    vec++;
    if ({bus.i2c_exec, bus.slave_addr} !== {1'b1, 7'h10}) begin
      errs++; $display("FAIL tie_first_m0: got exec=%b sa=%h want exec=1 sa=10", bus.i2c_exec, bus.slave_addr);
    end
    @(negedge clk); bus.i2c_done = 1;
    @(negedge clk); bus.i2c_done = 0;
    vec++;
    if ({bus.m0_done, bus.m1_done} !== 2'b10) begin
      errs++; $display("FAIL tie_m0_done: got %b want 10", {bus.m0_done, bus.m1_done});
    end
    // new m0 request coincident with m0_done, leaving a fresh tie with m1
    set_req(0, 1'b0, 7'h11, 16'h0011, 8'h00, 1'b0, 8'd1);
    bus.m0_exec = 1;
    @(negedge clk); bus.m0_exec = 0;
    vec++;
    if (bus.m0_busy !== 1'b1) begin errs++; $display("FAIL exec_on_done_accepted: got %b want 1", bus.m0_busy); end
    @(negedge clk);
    vec++;
    if ({bus.i2c_exec, bus.slave_addr} !== {1'b1, 7'h21}) begin
      errs++; $display("FAIL repeat_tie_m1_first: got exec=%b sa=%h want exec=1 sa=21", bus.i2c_exec, bus.slave_addr);
    end
    @(negedge clk); bus.i2c_done = 1;
    @(negedge clk); bus.i2c_done = 0;
    vec++;
    if ({bus.m0_done, bus.m1_done} !== 2'b01) begin
      errs++; $display("FAIL tie_m1_done: got %b want 01", {bus.m0_done, bus.m1_done});
    end
    @(negedge clk);
    @(negedge clk);
    vec++;
    if ({bus.i2c_exec, bus.slave_addr} !== {1'b1, 7'h11}) begin
      errs++; $display("FAIL repeat_tie_m0_second: got exec=%b sa=%h want exec=1 sa=11", bus.i2c_exec, bus.slave_addr);
    end
    @(negedge clk); bus.i2c_done = 1;
    @(negedge clk); bus.i2c_done = 0;
    @(negedge clk);
    vec++;
    if ({bus.m0_busy, bus.m1_busy} !== 2'b00) begin
      errs++; $display("FAIL tie_all_idle: got %b want 00", {bus.m0_busy, bus.m1_busy});
    end
  endtask

  task automatic test_read_m1();
    logic [7:0] bytes [4];
    int pulses = 0;
    int bad    = 0;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    set_req(1, 1'b1, 7'h30, 16'h0004, 8'h00, 1'b0, 8'd4);
    @(negedge clk); bus.m1_exec = 1;
    @(negedge clk); bus.m1_exec = 0;
    @(negedge clk);
    vec++;
    if ({bus.i2c_exec, bus.i2c_rh_wl, bus.reg_num, bus.slave_addr} !== {1'b1, 1'b1, 8'd4, 7'h30}) begin
      errs++; $display("FAIL read_issue: got exec=%b rw=%b rn=%0d sa=%h want 1 1 4 30",
                       bus.i2c_exec, bus.i2c_rh_wl, bus.reg_num, bus.slave_addr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.i2c_data_r = bytes[k]; bus.once_byte_done = 1; bus.i2c_ack = 1;
      #1;
      if (bus.m1_byte_done === 1'b1) pulses++;
      if (bus.m0_byte_done !== 1'b0) bad++;
      vec++;
      if (bus.m1_data_r !== bytes[k]) begin
        errs++; $display("FAIL read_byte%0d: got %h want %h", k, bus.m1_data_r, bytes[k]);
      end
      @(negedge clk); bus.once_byte_done = 0; bus.i2c_ack = 0;
      #1;
      if (bus.m1_byte_done !== 1'b0 || bus.m0_byte_done !== 1'b0) bad++;
    end
    vec++;
    if (pulses !== 4) begin errs++; $display("FAIL read_byte_done_pulses: got %0d want 4", pulses); end
    vec++;
    if (bad !== 0) begin errs++; $display("FAIL read_stray_byte_done: got %0d want 0", bad); end
    @(negedge clk); bus.i2c_done = 1;
    @(negedge clk); bus.i2c_done = 0;
    vec++;
    if ({bus.m1_done, bus.m1_err, bus.m1_data_r, bus.m0_data_r} !== {1'b1, 1'b0, 8'h44, 8'h00}) begin
      errs++; $display("FAIL read_done: got done=%b err=%b d1=%h d0=%h want 1 0 44 00",
                       bus.m1_done, bus.m1_err, bus.m1_data_r, bus.m0_data_r);
    end
    @(negedge clk);
    bus.i2c_data_r = '0;
  endtask

  task automatic test_busy_ignore();
    int nexec = 0;
    int bad   = 0;
    // responses outside WAIT must be ignored
    @(negedge clk); bus.i2c_done = 1; bus.once_byte_done = 1;
    #1;
    vec++;
    if ({bus.m0_byte_done, bus.m1_byte_done} !== 2'b00) begin
      errs++; $display("FAIL idle_byte_done_ignored: got %b want 00", {bus.m0_byte_done, bus.m1_byte_done});
    end
    @(negedge clk); bus.i2c_done = 0; bus.once_byte_done = 0;
    vec++;
    if ({bus.m0_done, bus.m1_done, bus.m0_busy, bus.m1_busy, bus.i2c_exec} !== 5'b0) begin
      errs++; $display("FAIL idle_done_ignored: got %b want 00000",
                       {bus.m0_done, bus.m1_done, bus.m0_busy, bus.m1_busy, bus.i2c_exec});
    end
    set_req(0, 1'b0, 7'h15, 16'h1234, 8'h77, 1'b1, 8'd2);
    @(negedge clk); bus.m0_exec = 1;
    @(negedge clk); bus.m0_exec = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.i2c_exec === 1'b1) nexec++;
      bus.m0_exec = (i == 0);   // second request while busy
    end
    vec++;
    if (nexec !== 1) begin errs++; $display("FAIL busy_single_exec: got %0d want 1", nexec); end
    bus.i2c_done = 1;
    @(negedge clk); bus.i2c_done = 0;
    vec++;
    if ({bus.m0_done, bus.m0_err} !== 2'b10) begin
      errs++; $display("FAIL busy_done: got %b want 10", {bus.m0_done, bus.m0_err});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.i2c_exec !== 1'b0 || bus.m0_busy !== 1'b0) bad++;
    end
    vec++;
    if (bad !== 0) begin errs++; $display("FAIL busy_request_dropped: got %0d want 0", bad); end
  endtask

  task automatic test_timeout();
    int early = 0;
    int bad   = 0;
    set_req(0, 1'b1, 7'h16, 16'h0020, 8'h00, 1'b0, 8'd1);
    @(negedge clk); bus.m0_exec = 1;
    @(negedge clk); bus.m0_exec = 0;
    @(negedge clk);
    vec++;
    if (bus.i2c_exec !== 1'b1) begin errs++; $display("FAIL timeout_issue: got %b want 1", bus.i2c_exec); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.m0_done !== 1'b0) early++;
    end
    vec++;
    if (early !== 0) begin errs++; $display("FAIL timeout_early_done: got %0d want 0", early); end
    @(negedge clk);
    vec++;
    if ({bus.m0_done, bus.m0_err} !== 2'b11) begin
      errs++; $display("FAIL timeout_done_err: got %b want 11", {bus.m0_done, bus.m0_err});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({bus.m0_done, bus.m0_err, bus.m0_busy, bus.i2c_exec} !== 4'b0) bad++;
    end
    vec++;
    if (bad !== 0) begin errs++; $display("FAIL timeout_back_idle: got %0d want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    set_req(1, 1'b0, 7'h22, 16'h5555, 8'hAA, 1'b1, 8'd3);
    bus.m0_data_w = 8'h33;
    @(negedge clk); bus.m1_exec = 1;
    @(negedge clk); bus.m1_exec = 0;
    @(negedge clk);
    @(negedge clk);
    bus.once_byte_done = 1; bus.i2c_ack = 1; bus.i2c_data_r = 8'h99;
    #1;
    vec++;
    if ({bus.m1_byte_done, bus.m1_data_r} !== {1'b1, 8'h99}) begin
      errs++; $display("FAIL rst_pre_wait_route: got %b %h want 1 99", bus.m1_byte_done, bus.m1_data_r);
    end
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (outs() !== '0) begin errs++; $display("FAIL rst_async_all_zero: got %h want 0", outs()); end
    clr_inputs();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if ({bus.i2c_exec, bus.m0_done, bus.m1_done, bus.m0_busy, bus.m1_busy} !== 5'b0) bad++;
      bus.i2c_done = (k == 2);
    end
    vec++;
    if (bad !== 0) begin errs++; $display("FAIL rst_no_done_after_release: got %0d want 0", bad); end
    vec++;
    if (outs() !== '0) begin errs++; $display("FAIL rst_release_quiet: got %h want 0", outs()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_read_m1();
    test_busy_ignore();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
